qarctan: RTL
============

# qarctan

Quantized arctangent stage of the FM demodulator. It accepts one (x, y) pair per transaction, where x and y are the real and imaginary parts of conj(prev)·cur. It forms the ratio operands, drives the external `divider` through its start/complete handshake, then scales and folds the quotient into a signed phase angle. The angle is quantized so that π = 3217 (BITS = 10). This block sits directly upstream of `divider`, feeding its dividend and divisor and consuming its quotient, and hands the resulting angle to the demodulator gain stage.

## Interface
- DATA_WIDTH, 32: width of x, y, divider operands, quotient and angle (signed).
- BITS, 10: quantization shift (QUANT_VAL = 2^BITS).
- QUAD1, 804: quantized π/4.
- QUAD3, 2412: quantized 3π/4.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  x/y valid.
- in_ready  out  1  block can accept x/y.
- in_x  in  DATA_WIDTH  signed real part.
- in_y  in  DATA_WIDTH  signed imaginary part.
- out_valid  out  1  out_angle valid.
- out_ready  in  1  downstream accepts angle.
- out_angle  out  DATA_WIDTH  signed quantized angle.
- out_err  out  1  divider reported overflow for this result (valid with out_valid).
- div_start  out  1  one-cycle start pulse to divider.
- div_dividend  out  DATA_WIDTH  divider dividend.
- div_divisor  out  DATA_WIDTH  divider divisor.
- div_quotient  in  DATA_WIDTH  divider quotient (signed, truncated toward zero).
- div_complete  in  1  divider done.
- div_overflow  in  1  divider overflow.

## Operation
- FSM states are IDLE, START, WAIT, SCALE and OUT.
  - IDLE: in_ready=1. On in_valid, register x and y and go to START.
  - START: div_start=1 for exactly this cycle, then go to WAIT.
  - WAIT: go to SCALE on div_complete, capturing div_quotient and div_overflow. div_complete is ignored on the first WAIT cycle (stale flag from the previous operation).
  - SCALE: register the angle, then go to OUT.
  - OUT: out_valid=1. On out_ready, go to IDLE.
- Operand computation:
  - abs_y = |y| + 1.
  - If x ≥ 0: dividend = (x − abs_y) << BITS and divisor = x + abs_y.
  - Else: dividend = (x + abs_y) << BITS and divisor = abs_y − x.
- div_dividend and div_divisor are driven from registered x/y and held stable from START until the block leaves WAIT. They are 0 in IDLE.
- Scaling:
  - p = QUAD1 · q, computed at 2·DATA_WIDTH signed.
  - s = p / 2^BITS, truncated toward zero: add 2^BITS − 1 when p < 0, then arithmetic shift right.
- Fold:
  - a = QUAD1 − s if x ≥ 0, else QUAD3 − s.
  - out_angle = −a if y < 0, else a.
- Overflow handling: if div_overflow is captured, q is treated as 0 and out_err=1. The computed operands never give a zero divisor, so this flags a divider fault only.
- Precondition: |x|, |y| < 2^(DATA_WIDTH−BITS−2). Results outside this range are unspecified.

## Timing
- Reset values: in_ready=1, out_valid=0, out_angle=0, out_err=0, div_start=0, div_dividend=0, div_divisor=0. State is IDLE.
- An accept occurs on a rising edge with in_valid & in_ready. The next cycle is START.
- Latency: out_valid rises 2 cycles after the edge at which div_complete is sampled in WAIT (the SCALE cycle, then OUT).
- out_angle and out_err are held constant while out_valid=1 && out_ready=0.
- Throughput is one transaction in flight. in_ready=0 in all states except IDLE, and there is no accept in the same cycle as the out handshake.
- div_start is never asserted outside START. It is never asserted twice per transaction.
- An asynchronous reset in any state returns the block to IDLE immediately with the reset values. Any in-flight result is discarded; a later div_complete is ignored unless the block is in WAIT.
- out_ready held high in OUT gives a 1-cycle out_valid pulse.

## Test plan
- x=1024, y=0 -> dividend=1047552, divisor=1025, q=1022, out_angle=2, out_err=0.
- x=0, y=1024 -> dividend=−1049600, divisor=1025, q=−1024, out_angle=1608.
- x=−1024, y=0 -> dividend=−1047552, divisor=1025, q=−1022, out_angle=3214. Then x=0, y=−1024 -> out_angle=−1608.
- x=1024, y=1024 -> dividend=−1024, divisor=2049, q=0, out_angle=804. Hold out_ready=0 for 5 cycles: out_valid and out_angle stay stable, and in_ready=0 throughout.
- Divider model returns div_overflow=1 with q=12345 -> out_err=1, angle computed with q=0. The next transaction has out_err=0.
- Assert reset mid-WAIT, then release -> all outputs at reset values, in_ready=1. A late div_complete produces no out_valid. A new transaction completes correctly.

Source files
------------

// File: rtl/qarctan_if.sv
// Bundles the x/y input handshake, angle output handshake and divider port of qarctan.
// The slave modport is the qarctan view; the master modport is the surrounding logic.
interface qarctan_if #(
   parameter int DATA_WIDTH = 32
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_x;
   logic signed [DATA_WIDTH-1:0] in_y;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [DATA_WIDTH-1:0] out_angle;
   logic                         out_err;
   logic                         div_start;
   logic signed [DATA_WIDTH-1:0] div_dividend;
   logic signed [DATA_WIDTH-1:0] div_divisor;
   logic signed [DATA_WIDTH-1:0] div_quotient;
   logic                         div_complete;
   logic                         div_overflow;

   modport slave (
      input  in_valid, in_x, in_y, out_ready, div_quotient, div_complete, div_overflow,
      output in_ready, out_valid, out_angle, out_err, div_start, div_dividend, div_divisor
   );

   modport master (
      output in_valid, in_x, in_y, out_ready, div_quotient, div_complete, div_overflow,
      input  in_ready, out_valid, out_angle, out_err, div_start, div_dividend, div_divisor
   );
endinterface

// File: rtl/qarctan.sv
// Quantized arctangent of (x, y) via an external divider; one transaction in flight.
// Angle is valid two cycles after div_complete is taken and held until out_ready.
module qarctan #(
   parameter int DATA_WIDTH = 32,
   parameter int BITS       = 10,
   parameter int QUAD1      = 804,
   parameter int QUAD3      = 2412
) (
   input  logic     clock,
   input  logic     reset,
   qarctan_if.slave bus
);
   localparam int W         = DATA_WIDTH;
   localparam int QUANT_VAL = 1 << BITS;

   typedef enum logic [2:0] {IDLE, START, WAIT, SCALE, OUT} state_t;

   state_t              state_q, state_d;
   logic signed [W-1:0] x_q, x_d;
   logic signed [W-1:0] y_q, y_d;
   logic signed [W-1:0] q_q, q_d;
   logic                ovf_q, ovf_d;
   logic                first_q, first_d;
   logic signed [W-1:0] angle_q, angle_d;
   logic                err_q, err_d;

   logic signed [W-1:0]   abs_y, num, den;
   logic signed [W-1:0]   q_eff, s, a, angle_new;
   logic signed [2*W-1:0] p, p_adj;

   always_comb begin
      abs_y = (y_q[W-1] ? -y_q : y_q) + W'(1);
      if (!x_q[W-1]) begin
         num = (x_q - abs_y) <<< BITS;
         den = x_q + abs_y;
      end else begin
         num = (x_q + abs_y) <<< BITS;
         den = abs_y - x_q;
      end
   end

   // Divide by 2^BITS rounding toward zero: bias negative products before the shift.
   always_comb begin
      q_eff     = ovf_q ? '0 : q_q;
      p         = (2*W)'(q_eff) * (2*W)'(QUAD1);
      p_adj     = p[2*W-1] ? p + (2*W)'(QUANT_VAL - 1) : p;
      s         = W'(p_adj >>> BITS);
      a         = x_q[W-1] ? W'(QUAD3) - s : W'(QUAD1) - s;
      angle_new = y_q[W-1] ? -a : a;
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      q_d     = q_q;
      ovf_d   = ovf_q;
      first_d = first_q;
      angle_d = angle_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               x_d     = bus.in_x;
               y_d     = bus.in_y;
               state_d = START;
            end
         end
         START: begin
            first_d = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            // The divider's complete flag may still be set from the previous operation.
            first_d = 1'b0;
            if (bus.div_complete && !first_q) begin
               q_d     = bus.div_quotient;
               ovf_d   = bus.div_overflow;
               state_d = SCALE;
            end
         end
         SCALE: begin
            angle_d = angle_new;
            err_d   = ovf_q;
            state_d = OUT;
         end
         OUT: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         q_q     <= '0;
         ovf_q   <= 1'b0;
         first_q <= 1'b0;
         angle_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         q_q     <= q_d;
         ovf_q   <= ovf_d;
         first_q <= first_d;
         angle_q <= angle_d;
         err_q   <= err_d;
      end
   end

   assign bus.in_ready     = (state_q == IDLE);
   assign bus.out_valid    = (state_q == OUT);
   assign bus.out_angle    = angle_q;
   assign bus.out_err      = err_q;
   assign bus.div_start    = (state_q == START);
   assign bus.div_dividend = (state_q == START || state_q == WAIT) ? num : '0;
   assign bus.div_divisor  = (state_q == START || state_q == WAIT) ? den : '0;
endmodule
